// File: rtl/cpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : cpu_pkg                                               |
// | Purpose  : Shared instruction-field layout and the decoded       |
// |            register-field bundle passed from ID to EX.           |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package cpu_pkg;

  localparam int REG_IDX_W = 5;

  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;
  localparam int IMM_W = 16;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rs;
    logic [REG_IDX_W-1:0] rt;
    logic [REG_IDX_W-1:0] rd;
    logic [IMM_W-1:0]     imm;
  } id_bundle_t;

  // Only the operand-bearing low bits are passed in; the opcode is not decoded here.
  function automatic id_bundle_t decode_fields(input logic [RS_HI:0] instr);
    id_bundle_t b;
    b.rs  = instr[RS_HI:RS_LO];
    b.rt  = instr[RT_HI:RT_LO];
    b.rd  = instr[RD_HI:RD_LO];
    b.imm = instr[IMM_W-1:0];
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_bypass.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : regfile_bypass                                        |
// | Purpose  : Register array with one write port, reset init and    |
// |            two read ports that see a same-cycle write-back.      |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module regfile_bypass
  import cpu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int ZERO_REG   = 1,
  parameter int INIT_INDEX = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] rd_addr1,
  input  logic [REG_IDX_W-1:0] rd_addr2,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  output logic [XLEN-1:0]      rd_data1,
  output logic [XLEN-1:0]      rd_data2
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [AW-1:0]   wb_idx;
  logic [AW-1:0]   rd_idx1;
  logic [AW-1:0]   rd_idx2;
  logic            wb_write;

  // Upper index bits alias onto the smaller array and are intentionally ignored.
  assign wb_idx  = wb_addr[AW-1:0];
  assign rd_idx1 = rd_addr1[AW-1:0];
  assign rd_idx2 = rd_addr2[AW-1:0];

  generate
    if (AW < REG_IDX_W) begin : g_idx_hi
      logic unused_idx_hi;
      assign unused_idx_hi = ^{rd_addr1[REG_IDX_W-1:AW], rd_addr2[REG_IDX_W-1:AW],
                               wb_addr[REG_IDX_W-1:AW]};
    end
  endgenerate

  // Zero register (when enabled) is hard-wired: reads 0, write-back is dropped.
  function automatic logic [XLEN-1:0] bypass_read(
    input logic [AW-1:0]   idx,
    input logic [XLEN-1:0] stored,
    input logic            we,
    input logic [AW-1:0]   widx,
    input logic [XLEN-1:0] wdata
  );
    if (ZERO_REG != 0 && idx == '0) return '0;
    if (we && widx == idx) return wdata;
    return stored;
  endfunction

  // Write-enable qualified by the zero-register rule.
  always_comb begin
    wb_write = wb_en && !(ZERO_REG != 0 && wb_idx == '0);
  end

  // Next array contents: at most one entry changes per cycle.
  always_comb begin
    regs_d = regs_q;
    if (wb_write) regs_d[wb_idx] = wb_data;
  end

  // Array storage; reset seeds either the index value or zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (INIT_INDEX != 0) ? XLEN'(i) : '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Two read ports with write-through bypass.
  always_comb begin
    rd_data1 = bypass_read(rd_idx1, regs_q[rd_idx1], wb_en, wb_idx, wb_data);
    rd_data2 = bypass_read(rd_idx2, regs_q[rd_idx2], wb_en, wb_idx, wb_data);
  end

endmodule
`default_nettype wire

// File: rtl/id_regfile_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : id_regfile_stage                                      |
// | Purpose  : Instruction-decode stage: splits the instruction,     |
// |            reads two operands and presents them through a        |
// |            registered valid/ready slot with flush and            |
// |            operand refresh while stalled.                        |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module id_regfile_stage
  import cpu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int ZERO_REG   = 1,
  parameter int INIT_INDEX = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr_in,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_IDX_W-1:0] out_rs,
  output logic [REG_IDX_W-1:0] out_rt,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic [IMM_W-1:0]     out_imm,
  output logic [XLEN-1:0]      out_reg1,
  output logic [XLEN-1:0]      out_reg2,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_addr,
  input  logic [XLEN-1:0]      wb_data
);

  localparam int AW = $clog2(NREGS);

  id_bundle_t      in_fields;
  id_bundle_t      bundle_q, bundle_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] reg1_q, reg1_d;
  logic [XLEN-1:0] reg2_q, reg2_d;
  logic [XLEN-1:0] rd_data1, rd_data2;
  logic            accept;
  logic            holding;
  logic            hit_rs, hit_rt;
  logic [AW-1:0]   wb_idx, held_rs_idx, held_rt_idx;
  logic            unused_opcode;

  assign unused_opcode = ^instr_in[31:RS_HI+1];
  assign in_fields     = decode_fields(instr_in[RS_HI:0]);

  // Ready depends only on the output slot, never on in_valid.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign holding  = out_valid_q && !out_ready;

  assign wb_idx      = wb_addr[AW-1:0];
  assign held_rs_idx = bundle_q.rs[AW-1:0];
  assign held_rt_idx = bundle_q.rt[AW-1:0];

  regfile_bypass #(
    .XLEN       (XLEN),
    .NREGS      (NREGS),
    .ZERO_REG   (ZERO_REG),
    .INIT_INDEX (INIT_INDEX)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rd_addr1 (in_fields.rs),
    .rd_addr2 (in_fields.rt),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2)
  );

  // Write-back hitting a held operand index; keeps a stalled bundle from going stale.
  always_comb begin
    hit_rs = wb_en && (wb_idx == held_rs_idx) && !(ZERO_REG != 0 && held_rs_idx == '0);
    hit_rt = wb_en && (wb_idx == held_rt_idx) && !(ZERO_REG != 0 && held_rt_idx == '0);
  end

  // Output-slot next state: flush beats accept, accept beats drain, else hold/refresh.
  always_comb begin
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    reg1_d      = reg1_q;
    reg2_d      = reg2_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      bundle_d    = in_fields;
      reg1_d      = rd_data1;
      reg2_d      = rd_data2;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else if (holding) begin
      if (hit_rs) reg1_d = wb_data;
      if (hit_rt) reg2_d = wb_data;
    end
  end

  // Output-slot registers; reset drops any in-flight bundle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
      reg1_q      <= '0;
      reg2_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
      reg1_q      <= reg1_d;
      reg2_q      <= reg2_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_rs    = bundle_q.rs;
  assign out_rt    = bundle_q.rt;
  assign out_rd    = bundle_q.rd;
  assign out_imm   = bundle_q.imm;
  assign out_reg1  = reg1_q;
  assign out_reg2  = reg2_q;

endmodule
`default_nettype wire

// File: tb/tb_id_regfile_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_id_regfile_stage                                   |
// | Purpose  : Directed self-checking bench for id_regfile_stage     |
// |            (default build plus an 8-register build).             |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_id_regfile_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, flush, out_valid, out_ready, wb_en;
  logic [31:0] instr_in, wb_data, out_reg1, out_reg2;
  logic [4:0]  out_rs, out_rt, out_rd, wb_addr;
  logic [15:0] out_imm;

  logic        e_in_valid, e_in_ready, e_flush, e_out_valid, e_out_ready, e_wb_en;
  logic [31:0] e_instr, e_wb_data, e_reg1, e_reg2;
  logic [4:0]  e_rs, e_rt, e_rd, e_wb_addr;
  logic [15:0] e_imm;

  always #5 clk = ~clk;

  id_regfile_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr_in(instr_in), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_imm(out_imm),
    .out_reg1(out_reg1), .out_reg2(out_reg2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  id_regfile_stage #(.NREGS(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(e_in_valid), .in_ready(e_in_ready),
    .instr_in(e_instr), .flush(e_flush), .out_valid(e_out_valid), .out_ready(e_out_ready),
    .out_rs(e_rs), .out_rt(e_rt), .out_rd(e_rd), .out_imm(e_imm),
    .out_reg1(e_reg1), .out_reg2(e_reg2),
    .wb_en(e_wb_en), .wb_addr(e_wb_addr), .wb_data(e_wb_data)
  );

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] r1, r2;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mreg [32];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference read for the 32-entry, zero-register build.
  function automatic logic [31:0] mread(input logic [4:0] x, input logic we,
                                        input logic [4:0] wa, input logic [31:0] wd);
    if (x == 5'd0) return 32'd0;
    if (we && wa == x) return wd;
    return mreg[x];
  endfunction

  // One clock of stimulus on the main DUT; expectations come from the queue model.
  task automatic step(input logic v, input logic [31:0] ins, input logic ordy, input logic fl,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input string tag);
    exp_t e;
    logic mvalid, acc, hs;
    in_valid = v; instr_in = ins; out_ready = ordy; flush = fl;
    wb_en = we; wb_addr = wa; wb_data = wd;
    #1;
    mvalid = (exp_q.size() != 0);
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, (!mvalid || ordy)});
    acc = v && (!mvalid || ordy) && !fl;
    hs  = mvalid && ordy;
    @(posedge clk);
    if (hs) void'(exp_q.pop_front());
    if (fl) begin
      exp_q.delete();
    end else if (acc) begin
      e.rs  = ins[25:21];
      e.rt  = ins[20:16];
      e.rd  = ins[15:11];
      e.imm = ins[15:0];
      e.r1  = mread(ins[25:21], we, wa, wd);
      e.r2  = mread(ins[20:16], we, wa, wd);
      exp_q.push_back(e);
    end else if (mvalid && !ordy) begin
      e = exp_q[0];
      if (we && wa != 5'd0 && wa == e.rs) e.r1 = wd;
      if (we && wa != 5'd0 && wa == e.rt) e.r2 = wd;
      exp_q[0] = e;
    end
    if (we && wa != 5'd0) mreg[wa] = wd;
    #1;
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, (exp_q.size() != 0)});
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      chk({tag, ".rs"},   {27'd0, out_rs},  {27'd0, e.rs});
      chk({tag, ".rt"},   {27'd0, out_rt},  {27'd0, e.rt});
      chk({tag, ".rd"},   {27'd0, out_rd},  {27'd0, e.rd});
      chk({tag, ".imm"},  {16'd0, out_imm}, {16'd0, e.imm});
      chk({tag, ".reg1"}, out_reg1, e.r1);
      chk({tag, ".reg2"}, out_reg2, e.r2);
    end
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 0; instr_in = '0; flush = 0; out_ready = 0; wb_en = 0; wb_addr = '0; wb_data = '0;
    e_in_valid = 0; e_instr = '0; e_flush = 0; e_out_ready = 1; e_wb_en = 0; e_wb_addr = '0;
    e_wb_data = '0;
    for (int i = 0; i < 32; i++) mreg[i] = i;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst.rs",        {27'd0, out_rs},    32'd0);
    chk("rst.imm",       {16'd0, out_imm},   32'd0);
    chk("rst.reg1",      out_reg1,           32'd0);
    chk("rst.reg2",      out_reg2,           32'd0);
    chk("rst8.out_valid", {31'd0, e_out_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // 8-register build: rs=13 aliases to r5, rt=10 aliases to r2
    e_wb_en = 1; e_wb_addr = 5'd5; e_wb_data = 32'hAA;
    @(posedge clk); #1;
    e_wb_en = 0; e_in_valid = 1; e_instr = 32'h01AA_0000;
    @(posedge clk); #1;
    e_in_valid = 0;
    chk("alias.out_valid", {31'd0, e_out_valid}, 32'd1);
    chk("alias.rs",        {27'd0, e_rs},        32'd13);
    chk("alias.rt",        {27'd0, e_rt},        32'd10);
    chk("alias.reg1",      e_reg1,               32'hAA);
    chk("alias.reg2",      e_reg2,               32'd2);

    // Basic decode with index-initialised registers
    step(1, 32'h00A3_2800, 1, 0, 0, 5'd0, 32'h0, "basic");
    // Write-through bypass on the accept edge, then read-back
    step(1, 32'h00A3_2800, 1, 0, 1, 5'd5, 32'hDEAD_BEEF, "bypass");
    step(1, 32'h00A0_0000, 1, 0, 0, 5'd0, 32'h0, "readback");
    // rs=rt=7 held three cycles, write-back to r7 in the second
    step(1, 32'h00E7_1000, 1, 0, 0, 5'd0, 32'h0, "hold_acc");
    step(1, 32'h0022_1800, 0, 0, 0, 5'd0, 32'h0, "hold1");
    step(1, 32'h0022_1800, 0, 0, 1, 5'd7, 32'h1234, "hold2");
    step(1, 32'h0022_1800, 0, 0, 0, 5'd0, 32'h0, "hold3");
    step(0, 32'h0, 1, 0, 0, 5'd0, 32'h0, "hold_drain");
    // Zero register: write ignored, bypass suppressed
    step(0, 32'h0, 1, 0, 1, 5'd0, 32'hFFFF_FFFF, "z_wb");
    step(1, 32'h0000_0000, 1, 0, 0, 5'd0, 32'h0, "z_read");
    step(1, 32'h0000_0000, 1, 0, 1, 5'd0, 32'hFFFF_FFFF, "z_byp");
    // Streaming with a flush on the second instruction
    step(1, 32'h0109_5000, 1, 0, 0, 5'd0, 32'h0, "s_a");
    step(1, 32'h0211_4000, 1, 1, 1, 5'd9, 32'h0000_0099, "s_b_flush");
    step(1, 32'h0319_6000, 1, 0, 1, 5'd24, 32'hCAFE_0001, "s_c");
    step(1, 32'h0421_F000, 1, 0, 0, 5'd0, 32'h0, "s_d");
    step(1, 32'h0109_5000, 1, 0, 0, 5'd0, 32'h0, "s_e");
    // Refresh of rt only while stalled
    step(1, 32'h00A3_2800, 1, 0, 0, 5'd0, 32'h0, "rt_acc");
    step(0, 32'h0, 0, 0, 1, 5'd3, 32'h0000_0055, "rt_hold");
    step(0, 32'h0, 0, 0, 1, 5'd4, 32'h0000_0066, "rt_miss");
    // Flush of a held bundle
    step(1, 32'h0000_0000, 0, 1, 0, 5'd0, 32'h0, "hold_flush");
    step(0, 32'h0, 1, 0, 0, 5'd0, 32'h0, "idle");
    step(1, 32'h0060_0000, 1, 0, 0, 5'd0, 32'h0, "after_wb");

    // Asynchronous reset in the middle of a hold
    step(1, 32'h00E7_1000, 1, 0, 0, 5'd0, 32'h0, "ar_acc");
    step(0, 32'h0, 0, 0, 0, 5'd0, 32'h0, "ar_hold");
    #2;
    reset = 1'b0;
    #1;
    chk("areset.out_valid", {31'd0, out_valid}, 32'd0);
    chk("areset.in_ready",  {31'd0, in_ready},  32'd1);
    chk("areset.reg1",      out_reg1,           32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) mreg[i] = i;
    step(1, 32'h00A3_2800, 1, 0, 0, 5'd0, 32'h0, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
